// File: rtl/polyvec_stream_reader.sv
// polyvec_stream_reader: read-side streamer for a polyvec in uram_polyvec storage.
// Issues a contiguous run of URAM reads and absorbs the fixed read latency.
// Returned words go through a small output FIFO and leave as a valid/ready stream.
// Optional feature macro: POLYVEC_RD_ABORT_EN adds the abort input and the FLUSH state.
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// Once m_valid is raised, it and m_data hold until that transfer happens.
// The only exception is abort, which withdraws m_valid.
`timescale 1ns/1ps
module polyvec_stream_reader #(
    parameter int COE_WIDTH         = 35,
    parameter int ADDR_WIDTH        = 12,
    parameter int NUM_POLY          = 4,
    parameter int COMMON_URAM_DELAY = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [ADDR_WIDTH-1:0]                  start_addr,
    input  logic [ADDR_WIDTH:0]                    num_words,
    output logic                                   mem_en,
    output logic                                   we,
    output logic [ADDR_WIDTH-1:0]                  addr,
    input  logic [NUM_POLY-1:0][COE_WIDTH-1:0]     mem_dout,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [NUM_POLY-1:0][COE_WIDTH-1:0]     m_data,
    output logic                                   m_last,
    output logic                                   busy,
    output logic                                   done,
`ifdef POLYVEC_RD_ABORT_EN
    input  logic                                   abort,
`endif
    output logic [2:0]                             dbg_state
);
    // URAM read latency and the output FIFO depth.
    // A depth of L+2 lets one read issue every cycle while words are still in flight.
    localparam int L  = COMMON_URAM_DELAY + 1;
    localparam int D  = L + 2;
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);
    localparam int NW = ADDR_WIDTH + 1;

    typedef logic [NUM_POLY-1:0][COE_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NW-1:0]         rem_q, rem_d;
    logic [NW-1:0]         num_q, num_d;
    logic [NW-1:0]         beat_q, beat_d;
    logic [L-1:0]          vsr_q, vsr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    word_t                 fifo_mem_q [D];

    logic          abort_w;
    logic          abort_act;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] inflight;
    logic [CW:0]   occ;

`ifdef POLYVEC_RD_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign m_valid   = (cnt_q != '0);
    assign m_data    = fifo_mem_q[rd_ptr_q];
    assign m_last    = m_valid && (beat_q == num_q - NW'(1));
    assign mem_en    = issue;
    assign we        = 1'b0;
    assign addr      = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

    // Occupancy budget: a read issues only when every in-flight word is sure of a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) begin
            inflight = inflight + CW'(vsr_q[i]);
        end
        occ       = {1'b0, inflight} + {1'b0, cnt_q};
        abort_act = abort_w && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        issue     = (state_q == ST_RUN) && (rem_q != '0) && (occ < (CW + 1)'(D)) && !abort_act;
        push      = vsr_q[L-1] && !abort_act && (state_q != ST_FLUSH);
        pop       = m_valid && m_ready;
        vsr_d     = (vsr_q << 1) | L'(issue);
    end

    // Next-state logic for the FSM and the read and beat counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        num_d   = num_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = num_words;
                    num_d   = num_words;
                    beat_d  = '0;
                    state_d = (num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_act) begin
                    state_d = ST_FLUSH;
                end else if (issue && (rem_q == NW'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort_act) begin
                    state_d = ST_FLUSH;
                end else if (pop && m_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FLUSH: begin
                if (vsr_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (issue) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - NW'(1);
        end
        if (pop) begin
            beat_d = beat_q + NW'(1);
        end
    end

    // FIFO pointer and count update; abort empties the FIFO in one step.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (abort_act) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // State and counter registers.
    // Clearing vsr_q on reset discards words still inside the URAM pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            num_q    <= '0;
            beat_q   <= '0;
            vsr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            num_q    <= num_d;
            beat_q   <= beat_d;
            vsr_q    <= vsr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; a returning word is written in its return cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mem_dout;
        end
    end

endmodule

// File: tb/tb_polyvec_stream_reader.sv
// Testbench for polyvec_stream_reader.
// Uses a behavioural URAM model with two-cycle read latency and an in-order scoreboard.
`timescale 1ns/1ps
module tb_polyvec_stream_reader;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [11:0]      start_addr;
    logic [12:0]      num_words;
    logic             mem_en;
    logic             we;
    logic [11:0]      addr;
    logic [3:0][34:0] mem_dout;
    logic             m_valid;
    logic             m_ready;
    logic [3:0][34:0] m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic             abort;
    logic [2:0]       dbg_state;

    polyvec_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .num_words  (num_words),
        .mem_en     (mem_en),
        .we         (we),
        .addr       (addr),
        .mem_dout   (mem_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
`ifdef POLYVEC_RD_ABORT_EN
        .abort      (abort),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- URAM model ----------------
    logic [139:0] uram [4096];
    logic [139:0] s1, s2;
    assign mem_dout = s2;

    function automatic logic [139:0] word_of(input int k);
        logic [139:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*35 +: 35] = {3'(i), 12'(k), 20'(k * 7 + i)};
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (mem_en) s1 <= uram[addr];
        s2 <= s1;
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [139:0] exp_q[$];
    logic         last_q[$];
    int           issued   = 0;
    int           accepted = 0;
    int           done_cnt = 0;
    logic         sb_en    = 1'b1;
    logic         occ_en   = 1'b0;
    logic         stall_prev = 1'b0;
    logic [139:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n || !sb_en) begin
            stall_prev = 1'b0;
        end else begin
            if (mem_en) issued++;
            if (done) done_cnt++;
            if (stall_prev) chk("hold_stable", {19'd0, m_valid, m_data}, {19'd0, 1'b1, prev_data});
            if (m_valid && m_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 160'(exp_q.size() != 0), 160'(1));
                end else begin
                    logic [139:0] e;
                    logic         el;
                    e  = exp_q.pop_front();
                    el = last_q.pop_front();
                    chk("beat_data", {20'd0, m_data}, {20'd0, e});
                    chk("beat_last", 160'(m_last), 160'(el));
                end
            end
            if (occ_en) chk("occupancy", 160'((issued - accepted) <= D), 160'(1));
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- ready driver ----------------
    int rdy_mode = 1;   // 0: low, 1: high, 2: random 30% duty
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 99) < 30);
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic start_xfer(input int sa, input int n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 12'(sa);
        num_words  = 13'(n);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back(word_of((sa + j) % 4096));
            last_q.push_back(j == n - 1);
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_addr = 12'($urandom);
        num_words  = 13'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("done_seen", 160'(done), 160'(1));
    endtask

    task automatic wait_beats(input int target, input int budget);
        int c = 0;
        while (accepted < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("beats_reached", 160'(accepted >= target), 160'(1));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int c;
        int n;
        int d0;
        int i0;
        int base;

        for (int k = 0; k < 4096; k++) uram[k] = word_of(k);
        s1 = '0;
        s2 = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        num_words  = '0;
        abort      = 1'b0;
        m_ready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 160'({mem_en, we, m_valid, m_last, busy, done, addr, dbg_state}), 160'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full 4096-word run, m_ready high throughout
        d0 = done_cnt;
        start_xfer(0, 4096);
        chk("busy_c1", 160'(busy), 160'(1));
        chk("mem_en_c1", 160'(mem_en), 160'(1));
        chk("addr_c1", 160'(addr), 160'(0));
        c = 1;
        while (!m_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("first_valid_lat", 160'(c), 160'(4));
        n = 0;
        while (m_valid && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("no_gaps", 160'(n), 160'(4096));
        chk("done_after_last", 160'(done), 160'(1));
        @(posedge clk);
        #1;
        chk("idle_after_done", 160'({busy, done}), 160'(0));
        repeat (3) @(posedge clk);
        chk("done_once", 160'(done_cnt - d0), 160'(1));
        chk("sb_empty_full", 160'(exp_q.size()), 160'(0));

        // Address wrap 4094 -> 1; command inputs scrambled after acceptance
        start_xfer(4094, 4);
        wait_done(200);
        repeat (2) @(posedge clk);
        chk("sb_empty_wrap", 160'(exp_q.size()), 160'(0));

        // Random back-pressure at 30% ready duty
        rdy_mode = 2;
        occ_en   = 1'b1;
        start_xfer($urandom_range(0, 4095), 100);
        wait_done(3000);
        occ_en = 1'b0;
        repeat (2) @(posedge clk);
        chk("sb_empty_rand", 160'(exp_q.size()), 160'(0));
        rdy_mode = 1;

        // Zero-length start, plus a start while busy that must be ignored
        i0 = issued;
        d0 = done_cnt;
        start_xfer(5, 0);
        chk("zero_done_c1", 160'({done, busy, mem_en}), 160'(3'b110));
        start      = 1'b1;
        start_addr = 12'd10;
        num_words  = 13'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("zero_idle_c2", 160'({done, busy}), 160'(0));
        repeat (10) @(posedge clk);
        #1;
        chk("zero_no_reads", 160'(issued - i0), 160'(0));
        chk("zero_done_once", 160'(done_cnt - d0), 160'(1));
        chk("zero_no_valid", 160'(m_valid), 160'(0));

        // Reset asserted at beat 37 of a 100-word run
        base = accepted;
        start_xfer(200, 100);
        wait_beats(base + 37, 500);
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_mid", 160'({mem_en, we, m_valid, m_last, busy, done, addr}), 160'(0));
        exp_q.delete();
        last_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_en = 1'b1;
        start_xfer(7, 20);
        wait_done(300);
        repeat (2) @(posedge clk);
        chk("sb_empty_post_reset", 160'(exp_q.size()), 160'(0));

`ifdef POLYVEC_RD_ABORT_EN
        // Abort at beat 10 of 64
        d0   = done_cnt;
        base = accepted;
        start_xfer(300, 64);
        wait_beats(base + 10, 300);
        sb_en = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_mvalid", 160'(m_valid), 160'(0));
        c = 1;
        while (busy && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("abort_busy_fall", 160'(c <= 3), 160'(1));
        exp_q.delete();
        last_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 160'(done_cnt - d0), 160'(0));
        chk("abort_quiet", 160'({m_valid, busy}), 160'(0));
        sb_en = 1'b1;
        start_xfer(1000, 16);
        wait_done(300);
        repeat (2) @(posedge clk);
        chk("sb_empty_post_abort", 160'(exp_q.size()), 160'(0));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
